// File: rtl/vga_dac_palette_writer.sv
// CPU-side VGA DAC register block. It packs R,G,B byte writes into 18-bit palette RAM entries and
// prefetches palette entries from the RAM's read port so the CPU can read them back.
module vga_dac_palette_writer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        data_m_access,
    input  logic        data_m_wr_en,
    input  logic [1:0]  data_m_addr,
    input  logic [7:0]  data_m_data_in,
    output logic [7:0]  data_m_data_out,
    output logic        data_m_ack,
    output logic        dac_wr_en,
    output logic [7:0]  dac_wr_addr,
    output logic [17:0] dac_wr_data,
    output logic [7:0]  dac_rd_addr,
    input  logic [17:0] dac_rd_data,
    output logic [7:0]  pel_mask
);

    typedef enum logic {BUS_IDLE, BUS_WAIT} bus_state_e;
    typedef enum logic [1:0] {PF_IDLE, PF_FETCH, PF_CAPTURE} pf_state_e;

    bus_state_e  busState_q;
    pf_state_e   pfState_q;
    logic [7:0]  pelMask_q;
    logic [7:0]  wrIdx_q;
    logic [7:0]  rdIdx_q;
    logic [1:0]  wrComp_q;
    logic [1:0]  rdComp_q;
    logic        dacMode_q;
    logic [5:0]  stageR_q;
    logic [5:0]  stageG_q;
    logic [17:0] rdLatch_q;
    logic        latchValid_q;
    logic        ack_q;
    logic [7:0]  dataOut_q;
    logic        dacWrEn_q;
    logic [7:0]  dacWrAddr_q;
    logic [17:0] dacWrData_q;
    logic [7:0]  dacRdAddr_q;

    logic        accept;
    logic        isDataRead;
    logic        restart;
    logic        dataReady;
    logic        immRead;
    logic        waitDone;
    logic        readFire;
    logic [17:0] readEntry;

    function automatic logic [5:0] compSel(input logic [17:0] entry, input logic [1:0] comp);
        case (comp)
            2'd0:    compSel = entry[17:12];
            2'd1:    compSel = entry[11:6];
            default: compSel = entry[5:0];
        endcase
    endfunction

    // A RAM write landing on the entry being read back invalidates the latch and refetches it.
    assign restart    = dacWrEn_q && (dacWrAddr_q == rdIdx_q) && (latchValid_q || pfState_q != PF_IDLE);
    assign accept     = cs && data_m_access && !ack_q && (busState_q == BUS_IDLE);
    assign isDataRead = !data_m_wr_en && (data_m_addr == 2'd3);
    assign dataReady  = !restart && ((pfState_q == PF_CAPTURE) || latchValid_q);
    assign immRead    = accept && isDataRead && dataReady;
    assign waitDone   = (busState_q == BUS_WAIT) && dataReady;
    assign readFire   = immRead || waitDone;
    assign readEntry  = (pfState_q == PF_CAPTURE) ? dac_rd_data : rdLatch_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busState_q   <= BUS_IDLE;
            pfState_q    <= PF_IDLE;
            pelMask_q    <= 8'hFF;
            wrIdx_q      <= 8'h00;
            rdIdx_q      <= 8'h00;
            wrComp_q     <= 2'd0;
            rdComp_q     <= 2'd0;
            dacMode_q    <= 1'b0;
            stageR_q     <= 6'h00;
            stageG_q     <= 6'h00;
            rdLatch_q    <= 18'h0;
            latchValid_q <= 1'b0;
            ack_q        <= 1'b0;
            dataOut_q    <= 8'h00;
            dacWrEn_q    <= 1'b0;
            dacWrAddr_q  <= 8'h00;
            dacWrData_q  <= 18'h0;
            dacRdAddr_q  <= 8'h00;
        end else begin
            ack_q     <= 1'b0;
            dataOut_q <= 8'h00;
            dacWrEn_q <= 1'b0;

            case (pfState_q)
                PF_FETCH: pfState_q <= PF_CAPTURE;
                PF_CAPTURE: begin
                    rdLatch_q    <= dac_rd_data;
                    latchValid_q <= 1'b1;
                    pfState_q    <= PF_IDLE;
                end
                default: ;
            endcase

            // A waiting data read with nothing fetched or in flight kicks off its own fetch.
            if (restart) begin
                pfState_q    <= PF_FETCH;
                dacRdAddr_q  <= rdIdx_q;
                latchValid_q <= 1'b0;
            end else if (busState_q == BUS_WAIT && !dataReady && pfState_q == PF_IDLE) begin
                pfState_q    <= PF_FETCH;
                dacRdAddr_q  <= rdIdx_q;
                latchValid_q <= 1'b0;
            end

            if (accept) begin
                case (data_m_addr)
                    2'd0: begin
                        ack_q <= 1'b1;
                        if (data_m_wr_en) pelMask_q <= data_m_data_in;
                        else              dataOut_q <= pelMask_q;
                    end
                    2'd1: begin
                        ack_q <= 1'b1;
                        if (data_m_wr_en) begin
                            rdIdx_q      <= data_m_data_in;
                            rdComp_q     <= 2'd0;
                            dacMode_q    <= 1'b1;
                            pfState_q    <= PF_FETCH;
                            dacRdAddr_q  <= data_m_data_in;
                            latchValid_q <= 1'b0;
                        end else begin
                            dataOut_q <= {6'b000000, dacMode_q, dacMode_q};
                        end
                    end
                    2'd2: begin
                        ack_q <= 1'b1;
                        if (data_m_wr_en) begin
                            wrIdx_q   <= data_m_data_in;
                            wrComp_q  <= 2'd0;
                            stageR_q  <= 6'h00;
                            stageG_q  <= 6'h00;
                            dacMode_q <= 1'b0;
                        end else begin
                            dataOut_q <= wrIdx_q;
                        end
                    end
                    default: begin
                        if (data_m_wr_en) begin
                            ack_q <= 1'b1;
                            case (wrComp_q)
                                2'd0: begin
                                    stageR_q <= data_m_data_in[5:0];
                                    wrComp_q <= 2'd1;
                                end
                                2'd1: begin
                                    stageG_q <= data_m_data_in[5:0];
                                    wrComp_q <= 2'd2;
                                end
                                default: begin
                                    dacWrEn_q   <= 1'b1;
                                    dacWrAddr_q <= wrIdx_q;
                                    dacWrData_q <= {stageR_q, stageG_q, data_m_data_in[5:0]};
                                    wrIdx_q     <= wrIdx_q + 8'd1;
                                    wrComp_q    <= 2'd0;
                                end
                            endcase
                        end else if (!dataReady) begin
                            busState_q <= BUS_WAIT;
                        end
                    end
                endcase
            end

            // Completing the blue component advances to the next entry and prefetches it.
            if (readFire) begin
                ack_q      <= 1'b1;
                dataOut_q  <= {2'b00, compSel(readEntry, rdComp_q)};
                busState_q <= BUS_IDLE;
                if (rdComp_q == 2'd2) begin
                    rdComp_q     <= 2'd0;
                    rdIdx_q      <= rdIdx_q + 8'd1;
                    pfState_q    <= PF_FETCH;
                    dacRdAddr_q  <= rdIdx_q + 8'd1;
                    latchValid_q <= 1'b0;
                end else begin
                    rdComp_q <= rdComp_q + 2'd1;
                end
            end
        end
    end

    assign data_m_data_out = dataOut_q;
    assign data_m_ack      = ack_q;
    assign dac_wr_en       = dacWrEn_q;
    assign dac_wr_addr     = dacWrAddr_q;
    assign dac_wr_data     = dacWrData_q;
    assign dac_rd_addr     = dacRdAddr_q;
    assign pel_mask        = pelMask_q;

endmodule

// File: tb/tb_vga_dac_palette_writer.sv
// Scoreboard bench for vga_dac_palette_writer. Bus stimulus queues the expected read data and palette
// writes; monitors pop and compare them whenever the DUT acks or strobes the palette RAM.
module tb_vga_dac_palette_writer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cs;
   logic        data_m_access;
   logic        data_m_wr_en;
   logic [1:0]  data_m_addr;
   logic [7:0]  data_m_data_in;
   logic [7:0]  data_m_data_out;
   logic        data_m_ack;
   logic        dac_wr_en;
   logic [7:0]  dac_wr_addr;
   logic [17:0] dac_wr_data;
   logic [7:0]  dac_rd_addr;
   logic [17:0] dac_rd_data;
   logic [7:0]  pel_mask;

   int checks = 0;
   int errors = 0;

   logic [7:0]  expQ[$];
   logic [25:0] wrQ[$];

   logic [17:0] mem [256];
   logic        ramLoaded = 1'b0;

   vga_dac_palette_writer dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .cs              (cs),
      .data_m_access   (data_m_access),
      .data_m_wr_en    (data_m_wr_en),
      .data_m_addr     (data_m_addr),
      .data_m_data_in  (data_m_data_in),
      .data_m_data_out (data_m_data_out),
      .data_m_ack      (data_m_ack),
      .dac_wr_en       (dac_wr_en),
      .dac_wr_addr     (dac_wr_addr),
      .dac_wr_data     (dac_wr_data),
      .dac_rd_addr     (dac_rd_addr),
      .dac_rd_data     (dac_rd_data),
      .pel_mask        (pel_mask)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Palette RAM model: preload a few entries, then synchronous write plus 1-cycle synchronous read.
   always @(posedge clk) begin
      if (!ramLoaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= 18'h0;
         mem[8'h20] <= {6'h01, 6'h02, 6'h03};
         mem[8'h21] <= {6'h04, 6'h05, 6'h06};
         mem[8'h30] <= {6'h0A, 6'h0B, 6'h0C};
         ramLoaded  <= 1'b1;
      end else if (dac_wr_en) begin
         mem[dac_wr_addr] <= dac_wr_data;
      end
      dac_rd_data <= mem[dac_rd_addr];
   end

   // Monitor: every ack consumes one expected read value, every RAM strobe one expected write.
   always @(negedge clk) begin
      logic [7:0]  e;
      logic [25:0] w;
      if (reset_n && data_m_ack) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL ack_unexpected: got data %h, required no ack", data_m_data_out);
         end else begin
            e = expQ.pop_front();
            if (data_m_data_out !== e) begin
               errors++;
               $display("[TB] FAIL ack_data: got %h, required %h", data_m_data_out, e);
            end
         end
      end
      if (reset_n && dac_wr_en) begin
         checks++;
         if (wrQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL dac_wr_unexpected: got addr %h data %h, required no write",
                     dac_wr_addr, dac_wr_data);
         end else begin
            w = wrQ.pop_front();
            if ({dac_wr_addr, dac_wr_data} !== w) begin
               errors++;
               $display("[TB] FAIL dac_wr: got addr %h data %h, required addr %h data %h",
                        dac_wr_addr, dac_wr_data, w[25:18], w[17:0]);
            end
         end
      end
   end

   // One bus access: queue its expected ack data, hold access until ack, report cycles taken.
   task automatic applyStimulus(input logic wr, input logic [1:0] addr, input logic [7:0] din,
                                input logic [7:0] expRd, output int cycles);
      bit acked = 1'b0;
      expQ.push_back(wr ? 8'h00 : expRd);
      cs             = 1'b1;
      data_m_access  = 1'b1;
      data_m_wr_en   = wr;
      data_m_addr    = addr;
      data_m_data_in = din;
      cycles = 0;
      for (int n = 0; n < 20 && !acked; n++) begin
         @(negedge clk);
         cycles++;
         if (data_m_ack) acked = 1'b1;
      end
      data_m_access = 1'b0;
      cs            = 1'b0;
      if (!acked) begin
         checks++;
         errors++;
         $display("[TB] FAIL ack_timeout: got no ack after %0d cycles, required ack (addr %0d)", cycles, addr);
         if (expQ.size() != 0) void'(expQ.pop_back());
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
      end
   endtask

   task automatic writeReg(input logic [1:0] addr, input logic [7:0] din);
      int c;
      applyStimulus(1'b1, addr, din, 8'h00, c);
   endtask

   task automatic readReg(input logic [1:0] addr, input logic [7:0] expRd);
      int c;
      applyStimulus(1'b0, addr, 8'h00, expRd, c);
   endtask

   task automatic writeTriplet(input logic [7:0] idx, input logic [7:0] r, input logic [7:0] g,
                               input logic [7:0] b);
      wrQ.push_back({idx, r[5:0], g[5:0], b[5:0]});
      writeReg(2'd3, r);
      writeReg(2'd3, g);
      writeReg(2'd3, b);
   endtask

   initial begin
      int c;
      reset_n        = 1'b0;
      cs             = 1'b0;
      data_m_access  = 1'b0;
      data_m_wr_en   = 1'b0;
      data_m_addr    = 2'd0;
      data_m_data_in = 8'h00;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      $display("[TB] reset state");
      checkOutput("pel_mask_reset", {24'h0, pel_mask}, 32'hFF);
      checkOutput("dac_wr_en_reset", {31'h0, dac_wr_en}, 32'h0);
      readReg(2'd0, 8'hFF);
      readReg(2'd1, 8'h00);
      readReg(2'd2, 8'h00);

      $display("[TB] PEL mask");
      writeReg(2'd0, 8'h5A);
      checkOutput("pel_mask_write", {24'h0, pel_mask}, 32'h5A);
      readReg(2'd0, 8'h5A);

      $display("[TB] triplet write at 10h, upper data bits ignored");
      writeReg(2'd2, 8'h10);
      writeTriplet(8'h10, 8'hFF, 8'h15, 8'h2A);
      readReg(2'd2, 8'h11);

      $display("[TB] write index wrap and partial triplet drop");
      writeReg(2'd2, 8'hFF);
      writeTriplet(8'hFF, 8'h01, 8'h02, 8'h03);
      writeTriplet(8'h00, 8'h04, 8'h05, 8'h06);
      readReg(2'd2, 8'h01);
      writeReg(2'd3, 8'h07);
      writeReg(2'd3, 8'h08);
      writeReg(2'd2, 8'h05);
      writeTriplet(8'h05, 8'h09, 8'h0A, 8'h0B);

      $display("[TB] read-back across entries 20h and 21h");
      writeReg(2'd1, 8'h20);
      for (int i = 1; i <= 6; i++) readReg(2'd3, 8'(i));
      readReg(2'd1, 8'h03);

      $display("[TB] read stalls for prefetch, then refetches after overwrite");
      writeReg(2'd1, 8'h30);
      applyStimulus(1'b0, 2'd3, 8'h00, 8'h0A, c);
      checkOutput("prefetch_wait_cycles", c, 2);
      writeReg(2'd2, 8'h30);
      writeTriplet(8'h30, 8'h11, 8'h22, 8'h33);
      readReg(2'd3, 8'h22);
      readReg(2'd3, 8'h33);
      readReg(2'd1, 8'h00);

      $display("[TB] reset mid-triplet");
      writeReg(2'd2, 8'h40);
      writeReg(2'd3, 8'h01);
      writeReg(2'd3, 8'h02);
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("pel_mask_after_reset", {24'h0, pel_mask}, 32'hFF);
      readReg(2'd2, 8'h00);
      writeTriplet(8'h00, 8'h3C, 8'h3D, 8'h3E);

      repeat (10) @(negedge clk);
      checkOutput("ack_queue_drained", expQ.size(), 0);
      checkOutput("write_queue_drained", wrQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends on its own.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
